// File: rtl/tile_writeback.sv
// Tile writeback engine: collects MAC row results through a latency-matched
// delay line and writes them into OMEM, either overwriting or accumulating
// with per-lane signed saturation. Also performs the 16-row OMEM clear sweep.
module tile_writeback #(
    parameter int LAT = 3,
    parameter int PW  = 16
) (
    input  logic            CLK,
    input  logic            RSTN,
    input  logic            START_CALC,
    input  logic [1:0]      OBASE,
    input  logic            ACC,
    input  logic            CLR_OMEM,
    input  logic [4*PW-1:0] PSUM,
    input  logic [4*PW-1:0] OMEM_RDATA,
    output logic [3:0]      OMEM_ADDR,
    output logic            OMEM_RE,
    output logic            OMEM_WE,
    output logic [4*PW-1:0] OMEM_WDATA,
    output logic            Tile_Done,
    output logic            CLR_DONE,
    output logic            BUSY,
    output logic            ERR
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COLLECT = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Clear sweep counter: 0..15 are write cycles, 16 is the CLR_DONE cycle
    logic [4:0] clr_cnt_q, clr_cnt_d;
    logic [1:0] row_q, row_d;
    logic [1:0] obase_q, obase_d;
    logic       acc_q, acc_d;
    logic       err_q, err_d;

    // Delay line matching the MAC array latency; stage LAT-1 is the emerging entry
    logic [LAT-1:0]      dl_valid_q, dl_valid_d;
    logic [LAT-1:0][3:0] dl_addr_q, dl_addr_d;
    logic [LAT-1:0]      dl_acc_q, dl_acc_d;

    // Write stage: holds the row whose OMEM write happens this cycle
    logic            wb_valid_q, wb_valid_d;
    logic [3:0]      wb_addr_q, wb_addr_d;
    logic            wb_acc_q, wb_acc_d;
    logic [4*PW-1:0] psum_q, psum_d;

    logic       push;
    logic [1:0] push_obase;
    logic [1:0] push_row;
    logic       push_acc;

    logic       emerge_valid;
    logic [3:0] emerge_addr;
    logic       emerge_acc;
    logic       clearing;

    logic [PW:0]     lane_sum [4];
    logic [4*PW-1:0] sat_sum;

    assign emerge_valid = dl_valid_q[LAT-1];
    assign emerge_addr  = dl_addr_q[LAT-1];
    assign emerge_acc   = dl_acc_q[LAT-1];
    assign clearing     = (state_q == CLEAR) && !clr_cnt_q[4];

    // Control FSM next-state, tile capture, row counting and error detection
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        row_d      = row_q;
        obase_d    = obase_q;
        acc_d      = acc_q;
        err_d      = err_q;
        push       = 1'b0;
        push_obase = obase_q;
        push_row   = row_q;
        push_acc   = acc_q;

        if (state_q != IDLE && CLR_OMEM) begin
            err_d = 1'b1;
        end
        if ((state_q == DRAIN || state_q == DONE) && START_CALC) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (CLR_OMEM) begin
                    state_d   = CLEAR;
                    clr_cnt_d = 5'd0;
                    if (START_CALC) begin
                        err_d = 1'b1;
                    end
                end else if (START_CALC) begin
                    state_d    = COLLECT;
                    obase_d    = OBASE;
                    acc_d      = ACC;
                    push       = 1'b1;
                    push_obase = OBASE;
                    push_acc   = ACC;
                    push_row   = 2'd0;
                    row_d      = 2'd1;
                end
            end
            CLEAR: begin
                if (clr_cnt_q[4]) begin
                    state_d   = IDLE;
                    clr_cnt_d = 5'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            COLLECT: begin
                if (START_CALC) begin
                    push  = 1'b1;
                    row_d = row_q + 2'd1;
                    if (row_q == 2'd0) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!(|dl_valid_q)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = 2'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay line shift and write-stage capture of the emerging entry and its PSUM
    always_comb begin
        dl_valid_d    = '0;
        dl_addr_d     = '0;
        dl_acc_d      = '0;
        dl_valid_d[0] = push;
        dl_addr_d[0]  = {push_obase, push_row};
        dl_acc_d[0]   = push_acc;
        for (int i = 1; i < LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_addr_d[i]  = dl_addr_q[i-1];
            dl_acc_d[i]   = dl_acc_q[i-1];
        end
        wb_valid_d = emerge_valid;
        wb_addr_d  = emerge_addr;
        wb_acc_d   = emerge_acc;
        psum_d     = emerge_valid ? PSUM : psum_q;
    end

    // Per-lane signed saturating add of OMEM read data and the captured PSUM
    always_comb begin
        sat_sum = '0;
        for (int i = 0; i < 4; i++) begin
            lane_sum[i] = {OMEM_RDATA[i*PW+PW-1], OMEM_RDATA[i*PW +: PW]}
                        + {psum_q[i*PW+PW-1], psum_q[i*PW +: PW]};
            if (lane_sum[i][PW] != lane_sum[i][PW-1]) begin
                sat_sum[i*PW +: PW] = lane_sum[i][PW] ? {1'b1, {(PW-1){1'b0}}}
                                                      : {1'b0, {(PW-1){1'b1}}};
            end else begin
                sat_sum[i*PW +: PW] = lane_sum[i][PW-1:0];
            end
        end
    end

    // OMEM port drive: read address has priority, otherwise the pending write or clear address
    always_comb begin
        OMEM_RE    = emerge_valid & emerge_acc;
        OMEM_WE    = wb_valid_q | clearing;
        OMEM_ADDR  = 4'd0;
        OMEM_WDATA = '0;
        if (OMEM_RE) begin
            OMEM_ADDR = emerge_addr;
        end else if (wb_valid_q) begin
            OMEM_ADDR = wb_addr_q;
        end else if (clearing) begin
            OMEM_ADDR = clr_cnt_q[3:0];
        end
        if (wb_valid_q) begin
            OMEM_WDATA = wb_acc_q ? sat_sum : psum_q;
        end
        Tile_Done = (state_q == DONE);
        CLR_DONE  = (state_q == CLEAR) && clr_cnt_q[4];
        BUSY      = (state_q != IDLE);
        ERR       = err_q;
    end

    // State register; reset flushes the pipeline so no stale write survives
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            clr_cnt_q  <= 5'd0;
            row_q      <= 2'd0;
            obase_q    <= 2'd0;
            acc_q      <= 1'b0;
            err_q      <= 1'b0;
            dl_valid_q <= '0;
            dl_addr_q  <= '0;
            dl_acc_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 4'd0;
            wb_acc_q   <= 1'b0;
            psum_q     <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            row_q      <= row_d;
            obase_q    <= obase_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            dl_valid_q <= dl_valid_d;
            dl_addr_q  <= dl_addr_d;
            dl_acc_q   <= dl_acc_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_acc_q   <= wb_acc_d;
            psum_q     <= psum_d;
        end
    end

endmodule

// File: tb/tb_tile_writeback.sv
// Directed bench for tile_writeback with a 1R1W OMEM model.
module tb_tile_writeback;

    localparam int LAT = 3;
    localparam int PW  = 16;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START_CALC = 1'b0;
    logic [1:0]  OBASE = 2'd0;
    logic        ACC = 1'b0;
    logic        CLR_OMEM = 1'b0;
    logic [63:0] PSUM = 64'h0;
    logic [63:0] OMEM_RDATA;
    logic [3:0]  OMEM_ADDR;
    logic        OMEM_RE;
    logic        OMEM_WE;
    logic [63:0] OMEM_WDATA;
    logic        Tile_Done;
    logic        CLR_DONE;
    logic        BUSY;
    logic        ERR;

    int total = 0;
    int bad = 0;

    logic [63:0] mem [16];
    logic [63:0] rdata_q = 64'h0;
    logic [3:0]  raddr_q = 4'd0;
    int          we_count = 0;
    int          addr0_writes = 0;
    int          done_count = 0;
    logic [3:0]  waddr_now;

    logic [63:0] psum_rows [5];
    logic [63:0] exp_rows [5];

    int snap_we;
    int snap_done;
    int snap_a0;

    tile_writeback #(.LAT(LAT), .PW(PW)) dut (
        .CLK(CLK),
        .RSTN(RSTN),
        .START_CALC(START_CALC),
        .OBASE(OBASE),
        .ACC(ACC),
        .CLR_OMEM(CLR_OMEM),
        .PSUM(PSUM),
        .OMEM_RDATA(OMEM_RDATA),
        .OMEM_ADDR(OMEM_ADDR),
        .OMEM_RE(OMEM_RE),
        .OMEM_WE(OMEM_WE),
        .OMEM_WDATA(OMEM_WDATA),
        .Tile_Done(Tile_Done),
        .CLR_DONE(CLR_DONE),
        .BUSY(BUSY),
        .ERR(ERR)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    assign OMEM_RDATA = rdata_q;
    assign waddr_now  = OMEM_RE ? raddr_q : OMEM_ADDR;

    // OMEM model: a write concurrent with a read targets the previously read row
    always @(posedge CLK) begin
        if (OMEM_RE) begin
            rdata_q <= mem[OMEM_ADDR];
            raddr_q <= OMEM_ADDR;
        end
        if (OMEM_WE) begin
            mem[waddr_now] <= OMEM_WDATA;
            we_count <= we_count + 1;
            if (waddr_now == 4'd0) begin
                addr0_writes <= addr0_writes + 1;
            end
        end
        if (Tile_Done) begin
            done_count <= done_count + 1;
        end
    end

    // Give up if the sequence overruns its time budget
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic start, input logic clr, input logic [1:0] ob,
                                  input logic acc, input logic [63:0] ps);
        @(posedge CLK);
        #1;
        START_CALC = start;
        CLR_OMEM   = clr;
        OBASE      = ob;
        ACC        = acc;
        PSUM       = ps;
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RSTN       = 1'b0;
        START_CALC = 1'b0;
        CLR_OMEM   = 1'b0;
        PSUM       = 64'h0;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
    endtask

    // One tile of n rows; OBASE/ACC are inverted after the first cycle to prove sampling
    task automatic run_tile(input logic [1:0] ob, input logic acc, input int n, input int clr_at);
        logic we_exp;
        logic re_exp;
        for (int t = 0; t <= LAT + n + 2; t++) begin
            apply_stimulus(t < n, t == clr_at, (t == 0) ? ob : ~ob, (t == 0) ? acc : ~acc,
                           (t >= LAT && t < LAT + n) ? psum_rows[t-LAT] : 64'h0);
            we_exp = (t >= LAT + 1) && (t <= LAT + n);
            re_exp = acc && (t >= LAT) && (t < LAT + n);
            check_output("we", {63'h0, OMEM_WE}, {63'h0, we_exp});
            check_output("re", {63'h0, OMEM_RE}, {63'h0, re_exp});
            if (re_exp) begin
                check_output("raddr", {60'h0, OMEM_ADDR}, {60'h0, ob, 2'(t - LAT)});
            end
            if (we_exp) begin
                check_output("wdata", OMEM_WDATA, exp_rows[t-LAT-1]);
            end
            if (we_exp && !re_exp) begin
                check_output("waddr", {60'h0, OMEM_ADDR}, {60'h0, ob, 2'(t - LAT - 1)});
            end
            check_output("tile_done", {63'h0, Tile_Done}, {63'h0, (t == LAT + n + 1)});
            check_output("busy", {63'h0, BUSY}, {63'h0, (t >= 1 && t <= LAT + n + 1)});
        end
    endtask

    // Directed sequence
    initial begin
        #2;
        check_output("reset_outs", {52'h0, OMEM_ADDR, OMEM_RE, OMEM_WE, Tile_Done, CLR_DONE, BUSY, ERR}, 64'h0);
        check_output("reset_wdata", OMEM_WDATA, 64'h0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;

        $display("[TB] clear sweep");
        for (int t = 0; t <= 18; t++) begin
            apply_stimulus(1'b0, t == 0, 2'd0, 1'b0, 64'h0);
            check_output("clr_we", {63'h0, OMEM_WE}, {63'h0, (t >= 1 && t <= 16)});
            if (t >= 1 && t <= 16) begin
                check_output("clr_addr", {60'h0, OMEM_ADDR}, 64'(t - 1));
                check_output("clr_wdata", OMEM_WDATA, 64'h0);
            end
            check_output("clr_done", {63'h0, CLR_DONE}, {63'h0, (t == 17)});
            check_output("clr_busy", {63'h0, BUSY}, {63'h0, (t >= 1 && t <= 17)});
        end

        $display("[TB] overwrite tile");
        psum_rows[0] = 64'h1111_2222_3333_4444;
        psum_rows[1] = 64'h8000_7FFF_FFFF_0000;
        psum_rows[2] = 64'hDEAD_BEEF_0123_4567;
        psum_rows[3] = 64'h0F0F_F0F0_AAAA_5555;
        for (int i = 0; i < 4; i++) exp_rows[i] = psum_rows[i];
        run_tile(2'd2, 1'b0, 4, -1);
        check_output("mem9", mem[9], 64'h8000_7FFF_FFFF_0000);

        $display("[TB] accumulate tile");
        for (int i = 0; i < 4; i++) begin
            psum_rows[i] = 64'h0064_0064_0064_0064;
            exp_rows[i]  = 64'h0064_0064_0064_0064;
        end
        run_tile(2'd1, 1'b0, 4, -1);
        for (int i = 0; i < 4; i++) begin
            psum_rows[i] = 64'h0005_0005_0005_0005;
            exp_rows[i]  = 64'h0069_0069_0069_0069;
        end
        run_tile(2'd1, 1'b1, 4, -1);
        check_output("mem4", mem[4], 64'h0069_0069_0069_0069);
        check_output("mem7", mem[7], 64'h0069_0069_0069_0069);

        $display("[TB] saturation, single-row tiles");
        psum_rows[0] = 64'hFFFB_03E8_8008_7FF8;
        exp_rows[0]  = 64'hFFFB_03E8_8008_7FF8;
        run_tile(2'd3, 1'b0, 1, -1);
        psum_rows[0] = 64'h0003_F830_FF9C_0064;
        exp_rows[0]  = 64'hFFFE_FC18_8000_7FFF;
        run_tile(2'd3, 1'b1, 1, -1);
        check_output("mem12", mem[12], 64'hFFFE_FC18_8000_7FFF);
        check_output("err_clean", {63'h0, ERR}, 64'h0);

        $display("[TB] clear during collect");
        psum_rows[0] = 64'h0000_0000_0000_0001;
        psum_rows[1] = 64'h0000_0000_0000_0002;
        psum_rows[2] = 64'h0000_0000_0000_0003;
        psum_rows[3] = 64'h0000_0000_0000_0004;
        for (int i = 0; i < 4; i++) exp_rows[i] = psum_rows[i];
        run_tile(2'd0, 1'b0, 4, 1);
        check_output("err_clr_collect", {63'h0, ERR}, 64'h1);
        check_output("mem12_kept", mem[12], 64'hFFFE_FC18_8000_7FFF);

        $display("[TB] five-cycle burst");
        do_reset();
        check_output("err_after_reset", {63'h0, ERR}, 64'h0);
        snap_a0 = addr0_writes;
        psum_rows[0] = 64'hA000_0000_0000_0000;
        psum_rows[1] = 64'hA100_0000_0000_0000;
        psum_rows[2] = 64'hA200_0000_0000_0000;
        psum_rows[3] = 64'hA300_0000_0000_0000;
        psum_rows[4] = 64'hA400_0000_0000_0000;
        for (int i = 0; i < 5; i++) exp_rows[i] = psum_rows[i];
        run_tile(2'd0, 1'b0, 5, -1);
        check_output("err_wrap", {63'h0, ERR}, 64'h1);
        check_output("row0_writes", 64'(addr0_writes - snap_a0), 64'd2);
        check_output("mem0", mem[0], 64'hA400_0000_0000_0000);

        $display("[TB] reset mid-tile");
        do_reset();
        for (int t = 0; t < 5; t++) begin
            apply_stimulus(t < 4, 1'b0, 2'd1, 1'b0, 64'h1234);
        end
        @(posedge CLK);
        #1;
        RSTN       = 1'b0;
        START_CALC = 1'b0;
        #1;
        check_output("midrst_outs", {52'h0, OMEM_ADDR, OMEM_RE, OMEM_WE, Tile_Done, CLR_DONE, BUSY, ERR}, 64'h0);
        check_output("midrst_wdata", OMEM_WDATA, 64'h0);
        snap_we   = we_count;
        snap_done = done_count;
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        for (int t = 0; t < 12; t++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
        end
        check_output("midrst_no_we", 64'(we_count - snap_we), 64'd0);
        check_output("midrst_no_done", 64'(done_count - snap_done), 64'd0);

        $display("[TB] clear and start together");
        snap_we   = we_count;
        snap_done = done_count;
        apply_stimulus(1'b1, 1'b1, 2'd2, 1'b0, 64'h0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
        check_output("both_busy", {63'h0, BUSY}, 64'h1);
        check_output("both_we", {63'h0, OMEM_WE}, 64'h1);
        check_output("both_addr", {60'h0, OMEM_ADDR}, 64'h0);
        check_output("both_err", {63'h0, ERR}, 64'h1);
        for (int t = 0; t < 17; t++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'h0);
        end
        check_output("both_idle", {63'h0, BUSY}, 64'h0);
        check_output("both_we_count", 64'(we_count - snap_we), 64'd16);
        check_output("both_no_done", 64'(done_count - snap_done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_writeback.md
TILE_WRITEBACK -- requirements
Module: tile_writeback

Interface
REQ-001 Parameter LAT, default 3: cycles from a START_CALC cycle to its PSUM row being valid; legal range 1-7.
REQ-002 Parameter PW, default 16: signed partial-sum width per lane; 4 lanes per row.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 START_CALC  input  1  calc enable from the tile controller; each high cycle emits one output row.
REQ-006 OBASE  input  2  {m[0],t[0]} output tile select; sampled on the first START_CALC cycle of a tile.
REQ-007 ACC  input  1  1 = accumulate into OMEM, 0 = overwrite; sampled with OBASE.
REQ-008 CLR_OMEM  input  1  1-cycle pulse; zero all 16 OMEM rows.
REQ-009 PSUM  input  4*PW  MAC array row output; lane i is at [i*PW +: PW].
REQ-010 OMEM_RDATA  input  4*PW  OMEM read data; valid 1 cycle after OMEM_RE.
REQ-011 OMEM_ADDR  output  4  OMEM row address {OBASE,row}.
REQ-012 OMEM_RE  output  1  OMEM read strobe.
REQ-013 OMEM_WE  output  1  OMEM write strobe.
REQ-014 OMEM_WDATA  output  4*PW  OMEM write data.
REQ-015 Tile_Done  output  1  1-cycle pulse when all rows of a tile are written.
REQ-016 CLR_DONE  output  1  1-cycle pulse when the clear sweep completes.
REQ-017 BUSY  output  1  high in every state except IDLE.
REQ-018 ERR  output  1  sticky protocol-error flag; cleared only by reset.

Function
REQ-019 FSM states: IDLE, CLEAR, COLLECT, DRAIN, DONE.
REQ-020 IDLE->CLEAR on CLR_OMEM; IDLE->COLLECT on START_CALC; if both are asserted in the same cycle, CLEAR wins and ERR is set.
REQ-021 CLEAR: drive WE=1 and WDATA=0 for 16 consecutive cycles, ADDR 0..15; on the cycle after the write to address 15, pulse CLR_DONE and go to IDLE.
REQ-022 COLLECT: each START_CALC cycle pushes {OBASE,row,ACC} into a LAT-deep delay line; the 2-bit row counter starts at 0 and increments per START_CALC cycle.
REQ-023 START_CALC falling edge in COLLECT -> DRAIN; more than 4 START_CALC cycles wraps the row counter mod 4 and sets ERR.
REQ-024 Delay-line entry emerging at cycle k+LAT: ADDR={OBASE,row}; RE=ACC.
REQ-025 Write for that entry happens at cycle k+LAT+1 with WE=1 and the same address.
REQ-026 Write data: ACC=0 gives WDATA=PSUM registered at k+LAT; ACC=1 gives a per-lane signed saturating sum of OMEM_RDATA and that registered PSUM.
REQ-027 Saturation bounds are 2^(PW-1)-1 and -2^(PW-1); there is no cross-lane carry.
REQ-028 DRAIN ends when the delay line is empty and the last write is done -> DONE.
REQ-029 DONE: Tile_Done=1 for exactly one cycle, then IDLE.
REQ-030 Latency: for a 4-cycle burst whose first START_CALC cycle is s, the writes occur at s+LAT+1 .. s+LAT+4 and Tile_Done at s+LAT+5.
REQ-031 A START_CALC in DRAIN or DONE is ignored and sets ERR.
REQ-032 A CLR_OMEM in any state other than IDLE is ignored and sets ERR.
REQ-033 ADDR/RE timing: the write address and the read address of different rows never coincide in one cycle; when both are active in the same cycle, OMEM_ADDR carries the read address and the write uses a separate registered address.
REQ-034 For REQ-033, the OMEM port is modelled as 1R1W: OMEM_ADDR is the read address, and the write address is {OBASE,row} of the pending write held in the WE stage, exposed on OMEM_ADDR whenever RE=0.

Reset
REQ-035 RSTN low: state IDLE, delay line flushed, row counter 0, ERR 0.
REQ-036 RSTN low: all outputs 0, including WDATA, ADDR, Tile_Done, CLR_DONE and BUSY.
REQ-037 Reset mid-tile or mid-clear discards all pending writes; no WE is issued after RSTN deassertion until new stimulus arrives.

Verification
REQ-038 Clear sweep: CLR_OMEM pulse -> 16 writes of 0 at ADDR 0..15 on consecutive cycles; CLR_DONE one cycle after the write to address 15; BUSY high for 17 cycles.
REQ-039 Overwrite, LAT=3, OBASE=2, ACC=0: 4-cycle START_CALC from s with PSUM rows P0..P3 -> writes to ADDR 8..11 at s+4..s+7; Tile_Done at s+8; RE never high.
REQ-040 Accumulate, ACC=1: OMEM rows preloaded with lanes=100 and PSUM lanes=5 -> written lanes=105; RE leads each WE by one cycle.
REQ-041 Saturation, PW=16: OMEM lane 32760 + PSUM 100 -> 32767; OMEM lane -32760 + PSUM -100 -> -32768.
REQ-042 Errors: CLR_OMEM during COLLECT -> ERR=1 and the tile completes normally; a 5-cycle START_CALC -> ERR=1 and row 0 is written twice.
REQ-043 Reset mid-tile: RSTN asserted at s+5 -> all outputs 0 immediately; no WE and no Tile_Done after release.
